cpu_r_mc_ctrl: RTL

Multi-cycle instruction sequencer for the R-type CPU datapath (PC, instruction register, register file, ALU).

- Steps each instruction through fetch, decode, execute and write-back states.
- Decodes `OP`/`func` into the 3-bit `ALU_OP`.
- Gates `PC_Write`, `IR_Write` and `Write_Reg`, latches the ALU flags and counts retired instructions.
- Sits between the instruction register and the datapath write enables.
- Supports free-run and single-step operation for bench and board debug.

---
 rtl/cpu_r_mc_ctrl_if.sv | 36 +++
 rtl/cpu_r_mc_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/cpu_r_mc_ctrl_if.sv
// Control bus between the multi-cycle sequencer and the rest of the CPU:
// run/step controls, instruction fields, ALU flags and the datapath enables.
interface cpu_r_mc_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             Run;
    logic             Step;
    logic [5:0]       OP;
    logic [5:0]       func;
    logic             ZF;
    logic             OF;
    logic             PC_Write;
    logic             IR_Write;
    logic             Write_Reg;
    logic [2:0]       ALU_OP;
    logic             ZF_Q;
    logic             OF_Q;
    logic             Illegal;
    logic             Busy;
    logic [2:0]       State;
    logic [CNT_W-1:0] Inst_Cnt;

    // Side driving instructions and run control (bench / instruction register).
    modport master (
        output Run, Step, OP, func, ZF, OF,
        input  PC_Write, IR_Write, Write_Reg, ALU_OP, ZF_Q, OF_Q,
               Illegal, Busy, State, Inst_Cnt
    );

    // Sequencer side.
    modport slave (
        input  Run, Step, OP, func, ZF, OF,
        output PC_Write, IR_Write, Write_Reg, ALU_OP, ZF_Q, OF_Q,
               Illegal, Busy, State, Inst_Cnt
    );
endinterface

// File: rtl/cpu_r_mc_ctrl.sv
// Multi-cycle sequencer for the R-type datapath: HOLD/IF/ID/EX/WB with an
// ERR trap for illegal instructions. Enables are Moore-decoded from the state
// register and forced low while Reset is high so a reset landing in WB can
// never produce a register-file write.
module cpu_r_mc_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         Reset,
    cpu_r_mc_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_HOLD = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_WB   = 3'd4,
        S_ERR  = 3'd7
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             legal_s;
    logic [2:0]       alu_dec_s;
    logic [2:0]       alu_op_r;
    logic             zf_q_r;
    logic             of_q_r;
    logic             illegal_r;
    logic [CNT_W-1:0] inst_cnt_r;

    // Decode func into an ALU select; only OP == 0 with a listed func is legal.
    always_comb begin
        legal_s   = 1'b0;
        alu_dec_s = 3'b000;
        if (bus.OP == 6'b000000) begin
            legal_s = 1'b1;
            case (bus.func)
                6'b100100: alu_dec_s = 3'b000;
                6'b100101: alu_dec_s = 3'b001;
                6'b100110: alu_dec_s = 3'b010;
                6'b100111: alu_dec_s = 3'b011;
                6'b100000: alu_dec_s = 3'b100;
                6'b100010: alu_dec_s = 3'b101;
                6'b101011: alu_dec_s = 3'b110;
                6'b000100: alu_dec_s = 3'b111;
                default: begin
                    legal_s   = 1'b0;
                    alu_dec_s = 3'b000;
                end
            endcase
        end else begin
            legal_s   = 1'b0;
            alu_dec_s = 3'b000;
        end
    end

    // Next-state logic; Step only matters in HOLD, unused codes fall to HOLD.
    always_comb begin
        state_nxt_s = S_HOLD;
        case (state_r)
            S_HOLD:  state_nxt_s = (bus.Run | bus.Step) ? S_IF : S_HOLD;
            S_IF:    state_nxt_s = S_ID;
            S_ID:    state_nxt_s = legal_s ? S_EX : S_ERR;
            S_EX:    state_nxt_s = S_WB;
            S_WB:    state_nxt_s = bus.Run ? S_IF : S_HOLD;
            S_ERR:   state_nxt_s = S_ERR;
            default: state_nxt_s = S_HOLD;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_r <= S_HOLD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // ALU select, latched flags, sticky illegal flag and retirement counter.
    always_ff @(posedge clk) begin
        if (Reset) begin
            alu_op_r   <= 3'b000;
            zf_q_r     <= 1'b0;
            of_q_r     <= 1'b0;
            illegal_r  <= 1'b0;
            inst_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if ((state_r == S_ID) && legal_s) begin
                alu_op_r <= alu_dec_s;
            end
            if ((state_r == S_ID) && !legal_s) begin
                illegal_r <= 1'b1;
            end
            if (state_r == S_EX) begin
                zf_q_r <= bus.ZF;
                of_q_r <= bus.OF;
            end
            if (state_r == S_WB) begin
                inst_cnt_r <= inst_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.PC_Write  = ~Reset & (state_r == S_IF);
    assign bus.IR_Write  = ~Reset & (state_r == S_IF);
    assign bus.Write_Reg = ~Reset & (state_r == S_WB);
    assign bus.Busy      = ~Reset & (state_r != S_HOLD) & (state_r != S_ERR);
    assign bus.ALU_OP    = Reset ? 3'b000 : alu_op_r;
    assign bus.ZF_Q      = ~Reset & zf_q_r;
    assign bus.OF_Q      = ~Reset & of_q_r;
    assign bus.Illegal   = ~Reset & illegal_r;
    assign bus.State     = Reset ? 3'd0 : state_r;
    assign bus.Inst_Cnt  = Reset ? {CNT_W{1'b0}} : inst_cnt_r;

endmodule
